dmem_stream: RTL

//  Parametrised streaming data memory for one PE tile of the spiral NN array. Replaces the fixed

---
 rtl/dmem_stream_pkg.sv | 8 +
 rtl/dmem_stream_if.sv | 42 ++++
 rtl/dmem_stream_agu.sv | 36 +++
 rtl/dmem_stream.sv | 104 ++++++++++
 4 files changed

// File: rtl/dmem_stream_pkg.sv
// dmem_stream_pkg: shared encodings and FSM states for the streaming data memory
package dmem_stream_pkg;
    localparam logic OP_WR  = 1'b0;
    localparam logic OP_RD  = 1'b1;
    localparam logic PORT_V = 1'b0;
    localparam logic PORT_H = 1'b1;
    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_DRAIN, S_DONE} state_t;
endpackage

// File: rtl/dmem_stream_if.sv
// dmem_stream_if: command, stream and status signals of one tile data memory
interface dmem_stream_if #(
    parameter int DataWidth = 32,
    parameter int AddrDMEM  = 10,
    parameter int LenWidth  = 11
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_op;
    logic                 cmd_port;
    logic [AddrDMEM-1:0]  cmd_base;
    logic [AddrDMEM-1:0]  cmd_stride;
    logic [LenWidth-1:0]  cmd_len;
    logic [DataWidth-1:0] v_s_i;
    logic                 v_s_i_valid;
    logic                 v_s_i_ready;
    logic [DataWidth-1:0] h_s_i;
    logic                 h_s_i_valid;
    logic                 h_s_i_ready;
    logic [DataWidth-1:0] v_s_o;
    logic                 v_s_o_valid;
    logic                 v_s_o_ready;
    logic [DataWidth-1:0] h_s_o;
    logic                 h_s_o_valid;
    logic                 h_s_o_ready;
    logic                 done;
    logic                 busy;

    modport slave (
        input  cmd_valid, cmd_op, cmd_port, cmd_base, cmd_stride, cmd_len,
        input  v_s_i, v_s_i_valid, h_s_i, h_s_i_valid, v_s_o_ready, h_s_o_ready,
        output cmd_ready, v_s_i_ready, h_s_i_ready,
        output v_s_o, v_s_o_valid, h_s_o, h_s_o_valid, done, busy
    );

    modport master (
        output cmd_valid, cmd_op, cmd_port, cmd_base, cmd_stride, cmd_len,
        output v_s_i, v_s_i_valid, h_s_i, h_s_i_valid, v_s_o_ready, h_s_o_ready,
        input  cmd_ready, v_s_i_ready, h_s_i_ready,
        input  v_s_o, v_s_o_valid, h_s_o, h_s_o_valid, done, busy
    );
endinterface

// File: rtl/dmem_stream_agu.sv
// dmem_stream_agu: burst address generator with modulo-depth wrap and remaining-beat count
module dmem_stream_agu #(
    parameter int AddrDMEM = 10,
    parameter int LenWidth = 11
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                step,
    input  logic [AddrDMEM-1:0] base,
    input  logic [AddrDMEM-1:0] stride,
    input  logic [LenWidth-1:0] len,
    output logic [AddrDMEM-1:0] addr,
    output logic                last
);
    logic [AddrDMEM-1:0] stride_q;
    logic [LenWidth-1:0] rem;

    assign last = rem == LenWidth'(1);

    // latch burst geometry on command, advance one stride per beat; wrap is the natural overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr     <= '0;
            stride_q <= '0;
            rem      <= '0;
        end else if (load) begin
            addr     <= base;
            stride_q <= stride;
            rem      <= len;
        end else if (step) begin
            addr     <= addr + stride_q;
            rem      <= rem - 1'b1;
        end
    end
endmodule

// File: rtl/dmem_stream.sv
// dmem_stream: command-driven burst write/read data memory between PE links
module dmem_stream
    import dmem_stream_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int AddrDMEM  = 10,
    parameter int LenWidth  = 11
) (
    input logic         clk,
    input logic         rst,
    dmem_stream_if.slave bus
);
    localparam int Depth = 2 ** AddrDMEM;

    state_t               state;
    logic                 port_q;
    logic                 cmd_ready_q;
    logic [DataWidth-1:0] mem [Depth];
    logic [DataWidth-1:0] o_data;
    logic                 o_valid;
    logic [AddrDMEM-1:0]  addr;
    logic                 last;
    logic                 accept;
    logic                 in_valid;
    logic [DataWidth-1:0] in_data;
    logic                 out_ready;
    logic                 wr_beat;
    logic                 rd_issue;

    assign accept    = bus.cmd_valid && cmd_ready_q;
    assign in_valid  = port_q == PORT_H ? bus.h_s_i_valid : bus.v_s_i_valid;
    assign in_data   = port_q == PORT_H ? bus.h_s_i : bus.v_s_i;
    assign out_ready = port_q == PORT_H ? bus.h_s_o_ready : bus.v_s_o_ready;
    assign wr_beat   = state == S_WR && in_valid;
    // a new read may issue whenever the output register is free or drains this cycle
    assign rd_issue  = state == S_RD && (!o_valid || out_ready);

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.busy        = state != S_IDLE;
    assign bus.done        = state == S_DONE;
    assign bus.v_s_i_ready = state == S_WR && port_q == PORT_V;
    assign bus.h_s_i_ready = state == S_WR && port_q == PORT_H;
    assign bus.v_s_o_valid = o_valid && port_q == PORT_V;
    assign bus.h_s_o_valid = o_valid && port_q == PORT_H;
    assign bus.v_s_o       = bus.v_s_o_valid ? o_data : '0;
    assign bus.h_s_o       = bus.h_s_o_valid ? o_data : '0;

    dmem_stream_agu #(.AddrDMEM(AddrDMEM), .LenWidth(LenWidth)) u_agu (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .step   (wr_beat || rd_issue),
        .base   (bus.cmd_base),
        .stride (bus.cmd_stride),
        .len    (bus.cmd_len),
        .addr   (addr),
        .last   (last)
    );

    // burst sequencer; cmd_ready comes up one cycle after reset release and after each burst
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            port_q      <= PORT_V;
            cmd_ready_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    cmd_ready_q <= !accept;
                    if (accept) begin
                        port_q <= bus.cmd_port;
                        state  <= bus.cmd_len == '0 ? S_DONE : bus.cmd_op == OP_RD ? S_RD : S_WR;
                    end
                end
                S_WR:    if (wr_beat && last) state <= S_DONE;
                S_RD:    if (rd_issue && last) state <= S_DRAIN;
                S_DRAIN: if (!o_valid || out_ready) state <= S_DONE;
                S_DONE: begin
                    state       <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // array write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (wr_beat) mem[addr] <= in_data;
    end

    // one-entry output register doubling as the synchronous read register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_valid <= 1'b0;
            o_data  <= '0;
        end else if (rd_issue) begin
            o_valid <= 1'b1;
            o_data  <= mem[addr];
        end else if (out_ready) begin
            o_valid <= 1'b0;
        end
    end
endmodule
